sync_ram_dp_param: RTL and testbench
====================================

# sync_ram_dp_param

Parametrised simple-dual-port synchronous RAM: one write port and one read port, both on `clk`. It supports same-cycle read and write, with a defined collision policy instead of rejecting the access. A sequential clear engine initialises the array one word per cycle after reset. Optional pipelined read latency and a compile-time parity check are provided. The block is the general storage primitive for buffers and lookup tables across the design.

## Interface
- `DATA_WIDTH`, 8: word width in bits, ≥1.
- `DEPTH`, 512: number of words, ≥2; need not be a power of two.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: address width.
- `READ_LATENCY`, 1: 1 or 2 cycles from `rd_enb` to data.
- `RD_MODE`, 0: same-address collision policy. 0 = read-first (old data), 1 = write-first (new data).
- `INIT_VALUE`, 0: value written to every word by the clear engine.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `init_busy`  out  1  clear engine running; accesses ignored.
- `wr_enb`  in  1  write strobe.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `rd_enb`  in  1  read strobe.
- `rd_addr`  in  ADDR_WIDTH  read address.
- `rd_data`  out  DATA_WIDTH  read data; holds last value when no read completes.
- `rd_valid`  out  1  `rd_data` updated this cycle.
- `collision`  out  1  one-cycle pulse: a read and a write hit the same address; aligned with `rd_valid`.
- `access_err`  out  1  one-cycle pulse: a request was ignored (busy or out of range).
- `parity_err`  out  1  parity mismatch on read; aligned with `rd_valid`.

## Operation
- States are CLEAR and READY.
- Reset (`rst_n` low at an edge):
  - State → CLEAR, clear counter → 0.
  - `init_busy`=1; `rd_data`=0; `rd_valid`, `collision`, `access_err`, `parity_err` = 0; pipeline stage cleared.
- CLEAR, on each edge with `rst_n` high:
  - `ram[cnt]` ← `INIT_VALUE`, then `cnt`++.
  - After writing `DEPTH-1`, state → READY.
  - `init_busy` is therefore high for exactly `DEPTH` cycles with `rst_n` high.
  - Reset asserted mid-clear restarts the clear at address 0.
- In CLEAR, `wr_enb` and `rd_enb` are ignored. Each cycle with either strobe high produces an `access_err` pulse. `rd_valid` stays 0.
- READY, write: `wr_enb` with `wr_addr` < `DEPTH` updates the word at the edge.
- READY, read: `rd_enb` with `rd_addr` < `DEPTH` returns the word after `READ_LATENCY` cycles.
- Out-of-range address (≥ `DEPTH`):
  - Write is dropped.
  - Read returns 0 with `rd_valid`.
  - `access_err` pulses in both cases.
- Same-cycle read and write, different addresses: both complete, no flag.
- Same-cycle read and write, same in-range address:
  - Write completes.
  - Read returns old data (`RD_MODE`=0) or `wr_data` (`RD_MODE`=1).
  - `collision` pulses with that read's `rd_valid`.
- Back-to-back reads are fully pipelined: one result per cycle.

## Timing
- `READ_LATENCY`=1: `rd_enb` at edge N → `rd_data`/`rd_valid` valid after edge N+1.
- `READ_LATENCY`=2: valid after edge N+2. The extra stage is a register on data, valid, collision and parity flags.
- `access_err` is registered: it asserts after the edge at which the offending request was sampled.
- A write at edge N is visible to a read issued at edge N+1 (non-colliding).
- `init_busy` falls after the edge that writes address `DEPTH-1`. A request in that same cycle is still ignored.

## Configuration
- `SYNC_RAM_PARITY_EN` defined:
  - Array is `DATA_WIDTH+1` wide; an even-parity bit is stored on every write, including clear writes.
  - Array reads recompute parity; a mismatch pulses `parity_err` with `rd_valid`.
  - Write-first bypass data is never flagged.
- Not defined: array is `DATA_WIDTH` wide and `parity_err` is tied 0. The port is always present.

## Structure
- Package `sync_ram_pkg`:
  - State enum `{CLEAR, READY}`.
  - `RD_MODE` constants `RD_FIRST`=0, `WR_FIRST`=1.
  - Function computing parity of a word.
- Sub-module `sync_ram_clear_fsm`: state register and clear counter. Outputs `init_busy`, clear address, clear write enable.
- Array, collision compare and read pipeline live in the top.

## Test plan
- Reset clear, DEPTH=512: release `rst_n` → `init_busy` high exactly 512 cycles; then reads of 0, 255, 511 return `INIT_VALUE` (0).
- Read-first collision (`RD_MODE`=0): write 0xA5 to addr 10, then same-cycle write 0x3C / read addr 10 → `rd_data`=0xA5, `collision`=1; next read returns 0x3C.
- Write-first collision (`RD_MODE`=1), same sequence → `rd_data`=0x3C, `collision`=1.
- Latency 2: reads of addrs 1,2,3 on consecutive cycles, holding 0x11/0x22/0x33 → values appear on cycles N+2..N+4 with `rd_valid` continuous.
- Illegal access: DEPTH=300, write addr 400 and read during `init_busy` → `access_err` pulses, memory unchanged, read of addr 400 returns 0. Reset at clear count 100 → `init_busy` lasts 300 further cycles.
- Parity (`SYNC_RAM_PARITY_EN`): write 0x0F to addr 5, force-flip stored bit 0, read addr 5 → `parity_err`=1 with `rd_valid`. Without the macro → `parity_err`=0.

Source files
------------

// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM.
// Optional build macro: SYNC_RAM_PARITY_EN (stored even-parity bit per word).
package sync_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Same-address collision policies
  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  // Widest word the parity helper accepts; callers zero-extend to this width
  localparam int unsigned PARITY_MAX_W = 257;

  // Even-parity bit of a zero-extended word (XOR of all bits)
  function automatic logic word_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/sync_ram_clear_fsm.sv
// Post-reset clear engine: walks the array once, one word per cycle.
module sync_ram_clear_fsm
  import sync_ram_pkg::*;
#(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  // State and clear counter; reset restarts the walk at address 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and clear-write outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_busy = 1'b0;
    clr_we    = 1'b0;
    clr_addr  = cnt;
    case (state)
      CLEAR: begin
        init_busy = 1'b1;
        clr_we    = rst_n;
        if (cnt == LAST_ADDR) state_nxt = READY;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      READY: ;
      default: state_nxt = CLEAR;
    endcase
  end

endmodule

// File: rtl/sync_ram_dp_param.sv
// Simple-dual-port synchronous RAM with clear engine, collision policy and
// 1- or 2-cycle read latency.
// Optional build macro: SYNC_RAM_PARITY_EN (stored even-parity bit, parity_err).
module sync_ram_dp_param
  import sync_ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           DEPTH        = 512,
  parameter int unsigned           ADDR_WIDTH   = $clog2(DEPTH),
  parameter int unsigned           READ_LATENCY = 1,
  parameter int unsigned           RD_MODE      = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  collision,
  output logic                  access_err,
  output logic                  parity_err
);

`ifdef SYNC_RAM_PARITY_EN
  localparam int unsigned    MEM_W    = DATA_WIDTH + 1;
  localparam logic [MEM_W-1:0] CLR_WORD =
    {word_parity(PARITY_MAX_W'(INIT_VALUE)), INIT_VALUE};
`else
  localparam int unsigned    MEM_W    = DATA_WIDTH;
  localparam logic [MEM_W-1:0] CLR_WORD = INIT_VALUE;
`endif
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [MEM_W-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  wr_in, rd_in, wr_ok, rd_ok, coll_now, bypass, err_now;
  logic [MEM_W-1:0]      wr_word, rd_word;
  logic                  rd_word_perr;

  logic                  s1_valid, s1_coll, s1_perr;
  logic [DATA_WIDTH-1:0] s1_data;

  sync_ram_clear_fsm #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we)
  );

  // Request qualification, collision detect and array read word
  always_comb begin
    wr_in    = {1'b0, wr_addr} < DEPTH_LIM;
    rd_in    = {1'b0, rd_addr} < DEPTH_LIM;
    wr_ok    = !init_busy && wr_enb && wr_in;
    rd_ok    = !init_busy && rd_enb;
    coll_now = rd_ok && rd_in && wr_ok && (rd_addr == wr_addr);
    bypass   = coll_now && (RD_MODE == WR_FIRST);
    err_now  = init_busy ? (wr_enb || rd_enb)
                         : ((wr_enb && !wr_in) || (rd_enb && !rd_in));
    rd_word  = mem[rd_addr];
`ifdef SYNC_RAM_PARITY_EN
    wr_word      = {word_parity(PARITY_MAX_W'(wr_data)), wr_data};
    rd_word_perr = word_parity(PARITY_MAX_W'(rd_word));
`else
    wr_word      = wr_data;
    rd_word_perr = 1'b0;
`endif
  end

  // Array write port, shared between the clear engine and user writes
  always_ff @(posedge clk) begin
    if (clr_we)     mem[clr_addr] <= CLR_WORD;
    else if (wr_ok) mem[wr_addr]  <= wr_word;
  end

  // First read stage; data register only moves when a read completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_coll    <= 1'b0;
      s1_perr    <= 1'b0;
      access_err <= 1'b0;
    end else begin
      s1_valid   <= rd_ok;
      s1_coll    <= coll_now;
      s1_perr    <= rd_ok && rd_in && !bypass && rd_word_perr;
      access_err <= err_now;
      if (rd_ok) begin
        if (!rd_in)      s1_data <= '0;
        else if (bypass) s1_data <= wr_data;
        else             s1_data <= rd_word[DATA_WIDTH-1:0];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid, s2_coll, s2_perr;
      logic [DATA_WIDTH-1:0] s2_data;

      // Extra output stage on data and all read-aligned flags
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
          s2_coll  <= 1'b0;
          s2_perr  <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          s2_coll  <= s1_coll;
          s2_perr  <= s1_perr;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_data    = s2_data;
      assign rd_valid   = s2_valid;
      assign collision  = s2_coll;
      assign parity_err = s2_perr;
    end else begin : g_lat1
      assign rd_data    = s1_data;
      assign rd_valid   = s1_valid;
      assign collision  = s1_coll;
      assign parity_err = s1_perr;
    end
  endgenerate

endmodule

// File: tb/tb_sync_ram_dp_param.sv
// Bench for sync_ram_dp_param: instance A (512 deep, latency 1, read-first,
// init 0) and instance B (300 deep, latency 2, write-first, init 0x5A).
module tb_sync_ram_dp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_busy, a_we, a_re, a_valid, a_coll, a_err, a_perr;
  logic [8:0] a_wa, a_ra;
  logic [7:0] a_wd, a_rd;
  logic       b_rst_n, b_busy, b_we, b_re, b_valid, b_coll, b_err, b_perr;
  logic [8:0] b_wa, b_ra;
  logic [7:0] b_wd, b_rd;

  sync_ram_dp_param #(
    .DATA_WIDTH(8), .DEPTH(512), .READ_LATENCY(1), .RD_MODE(0), .INIT_VALUE(8'h00)
  ) dut_a (
    .clk(clk), .rst_n(a_rst_n), .init_busy(a_busy),
    .wr_enb(a_we), .wr_addr(a_wa), .wr_data(a_wd),
    .rd_enb(a_re), .rd_addr(a_ra), .rd_data(a_rd), .rd_valid(a_valid),
    .collision(a_coll), .access_err(a_err), .parity_err(a_perr)
  );

  sync_ram_dp_param #(
    .DATA_WIDTH(8), .DEPTH(300), .READ_LATENCY(2), .RD_MODE(1), .INIT_VALUE(8'h5A)
  ) dut_b (
    .clk(clk), .rst_n(b_rst_n), .init_busy(b_busy),
    .wr_enb(b_we), .wr_addr(b_wa), .wr_data(b_wd),
    .rd_enb(b_re), .rd_addr(b_ra), .rd_data(b_rd), .rd_valid(b_valid),
    .collision(b_coll), .access_err(b_err), .parity_err(b_perr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic we, input int wa, input logic [7:0] wd,
                         input logic re, input int ra);
    a_we = we; a_wa = 9'(wa); a_wd = wd; a_re = re; a_ra = 9'(ra);
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input logic we, input int wa, input logic [7:0] wd,
                         input logic re, input int ra);
    b_we = we; b_wa = 9'(wa); b_wd = wd; b_re = re; b_ra = 9'(ra);
    @(posedge clk); #1;
  endtask

  // Counts edges while init_busy is high (bounded) and access_err pulses seen
  task automatic count_busy(input bit sel, output int n, output int errs);
    n = 0; errs = 0;
    while ((sel ? b_busy : a_busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (sel ? b_err : a_err) errs++;
    end
  endtask

  typedef struct {
    logic       we;
    int         wa;
    logic [7:0] wd;
    logic       re;
    int         ra;
    logic       ev;
    logic [7:0] ed;
    logic       ec;
  } vec_t;

  vec_t va[13];

  initial begin
    int n, errs;

    va[0]  = '{1'b0,   0, 8'h00, 1'b1,   0, 1'b1, 8'h00, 1'b0};
    va[1]  = '{1'b0,   0, 8'h00, 1'b1, 255, 1'b1, 8'h00, 1'b0};
    va[2]  = '{1'b0,   0, 8'h00, 1'b1, 511, 1'b1, 8'h00, 1'b0};
    va[3]  = '{1'b1,  10, 8'hA5, 1'b0,   0, 1'b0, 8'h00, 1'b0};
    va[4]  = '{1'b1,  10, 8'h3C, 1'b1,  10, 1'b1, 8'hA5, 1'b1};
    va[5]  = '{1'b0,   0, 8'h00, 1'b1,  10, 1'b1, 8'h3C, 1'b0};
    va[6]  = '{1'b1,  20, 8'h77, 1'b1,  21, 1'b1, 8'h00, 1'b0};
    va[7]  = '{1'b0,   0, 8'h00, 1'b1,  20, 1'b1, 8'h77, 1'b0};
    va[8]  = '{1'b0,   0, 8'h00, 1'b0,   0, 1'b0, 8'h77, 1'b0};
    va[9]  = '{1'b1, 511, 8'hFF, 1'b1, 511, 1'b1, 8'h00, 1'b1};
    va[10] = '{1'b0,   0, 8'h00, 1'b1, 511, 1'b1, 8'hFF, 1'b0};
    va[11] = '{1'b1,   0, 8'h01, 1'b1,   1, 1'b1, 8'h00, 1'b0};
    va[12] = '{1'b0,   0, 8'h00, 1'b1,   0, 1'b1, 8'h01, 1'b0};

    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_we = 0; a_wa = '0; a_wd = '0; a_re = 0; a_ra = '0;
    b_we = 0; b_wa = '0; b_wd = '0; b_re = 0; b_ra = '0;
    @(posedge clk); @(posedge clk); #1;

    // Reset state
    chk("A reset busy",  32'(a_busy),  1);
    chk("A reset data",  32'(a_rd),    0);
    chk("A reset valid", 32'(a_valid), 0);
    chk("A reset coll",  32'(a_coll),  0);
    chk("A reset err",   32'(a_err),   0);
    chk("A reset perr",  32'(a_perr),  0);
    chk("B reset busy",  32'(b_busy),  1);
    chk("B reset data",  32'(b_rd),    0);

    // Instance A: full clear then vector table
    a_rst_n = 1'b1;
    count_busy(1'b0, n, errs);
    chk("A clear cycles", 32'(n), 512);
    chk("A clear errs",   32'(errs), 0);

    for (int i = 0; i < 13; i++) begin
      drive_a(va[i].we, va[i].wa, va[i].wd, va[i].re, va[i].ra);
      chk($sformatf("A vec%0d valid", i), 32'(a_valid), 32'(va[i].ev));
      chk($sformatf("A vec%0d data", i),  32'(a_rd),    32'(va[i].ed));
      chk($sformatf("A vec%0d coll", i),  32'(a_coll),  32'(va[i].ec));
      chk($sformatf("A vec%0d err", i),   32'(a_err),   0);
      chk($sformatf("A vec%0d perr", i),  32'(a_perr),  0);
    end

`ifdef SYNC_RAM_PARITY_EN
    drive_a(1, 5, 8'h0F, 0, 0);
    dut_a.mem[5][0] = ~dut_a.mem[5][0];
    drive_a(0, 0, 8'h00, 1, 5);
    chk("A parity perr",  32'(a_perr),  1);
    chk("A parity valid", 32'(a_valid), 1);
    chk("A parity data",  32'(a_rd),    32'h0E);
`else
    drive_a(1, 5, 8'h0F, 0, 0);
    drive_a(0, 0, 8'h00, 1, 5);
    chk("A parity perr",  32'(a_perr),  0);
    chk("A parity data",  32'(a_rd),    32'h0F);
`endif
    drive_a(0, 0, 8'h00, 0, 0);

    // Instance B: reset mid-clear at count 100
    b_rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("B busy at 100", 32'(b_busy), 1);
    b_rst_n = 1'b0;
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    // Hold a write to addr 7 through the whole clear, including its last cycle
    b_we = 1; b_wa = 9'd7; b_wd = 8'hEE;
    count_busy(1'b1, n, errs);
    chk("B clear cycles",   32'(n),     300);
    chk("B clear errs",     32'(errs),  300);
    chk("B err last clear", 32'(b_err), 1);
    chk("B valid in clear", 32'(b_valid), 0);
    drive_b(0, 0, 8'h00, 0, 0);
    chk("B err idle", 32'(b_err), 0);

    // Write-first collision with latency 2
    drive_b(1, 10, 8'hA5, 0, 0);
    drive_b(1, 10, 8'h3C, 1, 10);
    chk("B coll lat valid", 32'(b_valid), 0);
    drive_b(0, 0, 8'h00, 0, 0);
    chk("B coll valid", 32'(b_valid), 1);
    chk("B coll data",  32'(b_rd),    32'h3C);
    chk("B coll flag",  32'(b_coll),  1);
    chk("B coll perr",  32'(b_perr),  0);
    drive_b(0, 0, 8'h00, 0, 0);
    chk("B post valid", 32'(b_valid), 0);
    chk("B post coll",  32'(b_coll),  0);
    chk("B hold data",  32'(b_rd),    32'h3C);

    // Pipelined back-to-back reads
    drive_b(1, 1, 8'h11, 0, 0);
    drive_b(1, 2, 8'h22, 0, 0);
    drive_b(1, 3, 8'h33, 0, 0);
    drive_b(0, 0, 8'h00, 1, 1);
    chk("B pipe v0", 32'(b_valid), 0);
    drive_b(0, 0, 8'h00, 1, 2);
    chk("B pipe v1", 32'(b_valid), 1);
    chk("B pipe d1", 32'(b_rd),    32'h11);
    drive_b(0, 0, 8'h00, 1, 3);
    chk("B pipe v2", 32'(b_valid), 1);
    chk("B pipe d2", 32'(b_rd),    32'h22);
    drive_b(0, 0, 8'h00, 0, 0);
    chk("B pipe v3", 32'(b_valid), 1);
    chk("B pipe d3", 32'(b_rd),    32'h33);
    drive_b(0, 0, 8'h00, 0, 0);
    chk("B pipe v4", 32'(b_valid), 0);

    // Out-of-range accesses
    drive_b(1, 400, 8'h77, 0, 0);
    chk("B oor wr err", 32'(b_err), 1);
    drive_b(0, 0, 8'h00, 1, 400);
    chk("B oor rd err", 32'(b_err),   1);
    chk("B oor rd lat", 32'(b_valid), 0);
    drive_b(0, 0, 8'h00, 0, 0);
    chk("B oor valid",  32'(b_valid), 1);
    chk("B oor data",   32'(b_rd),    0);
    chk("B oor err off", 32'(b_err),  0);

    // Memory untouched by ignored writes; last word still initialised
    drive_b(0, 0, 8'h00, 1, 7);
    drive_b(0, 0, 8'h00, 1, 299);
    chk("B addr7 valid", 32'(b_valid), 1);
    chk("B addr7 data",  32'(b_rd),    32'h5A);
    drive_b(0, 0, 8'h00, 0, 0);
    chk("B addr299 data", 32'(b_rd),   32'h5A);

    // Same-cycle read and write to different addresses
    drive_b(1, 50, 8'hC3, 1, 51);
    drive_b(0, 0, 8'h00, 1, 50);
    chk("B diff data", 32'(b_rd),   32'h5A);
    chk("B diff coll", 32'(b_coll), 0);
    drive_b(0, 0, 8'h00, 0, 0);
    chk("B diff wr data", 32'(b_rd),   32'hC3);
    chk("B diff wr coll", 32'(b_coll), 0);
    chk("B diff wr err",  32'(b_err),  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
